exe_mem_pipe_reg: RTL
=====================

// Module: exe_mem_pipe_reg
// PURPOSE
//  EXE->MEM pipeline boundary register with valid/ready handshake, flush and optional skid slot.
//  Sits between the execute stage (ALU result, store data, dest, WB/MEM controls) and the memory stage.
//  Lets the memory stage stall on a multi-cycle data memory without combinational ready paths upstream.
//  Payload widths are parametrised.
// PARAMETERS
//  DATA_W     32  width of alu_res / val_rm
//  DEST_W     4   width of destination register index
//  SKID       1   1: two-entry skid buffer, in_ready registered; 0: single entry, in_ready combinational
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  flush         in   1       synchronous squash of all held entries (branch taken)
//  in_valid      in   1       EXE beat valid
//  in_ready      out  1       register can accept a beat this cycle
//  in_wb         in   1       write-back enable
//  in_mem_read   in   1       load
//  in_mem_write  in   1       store
//  in_dest       in   DEST_W  destination register
//  in_alu_res    in   DATA_W  ALU result / memory address
//  in_val_rm     in   DATA_W  store data
//  out_valid     out  1       MEM beat valid
//  out_ready     in   1       MEM stage consumes beat this cycle
//  out_wb, out_mem_read, out_mem_write, out_dest, out_alu_res, out_val_rm   out   payload to MEM
//  occupancy     out  2       entries held: 0, 1, 2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset (async): out_valid=0, occupancy=0, all payload regs=0 (no X), in_ready=1 on first cycle after release.
//  - Accept when in_valid & in_ready at rising edge; consume when out_valid & out_ready. Latency 1 cycle:
//    beat accepted into empty register appears on outputs the next cycle.
//  - out_wb/out_mem_read/out_mem_write are gated with out_valid: 0 whenever out_valid=0. Data/dest hold last value.
//  - SKID=1 states: EMPTY (occ 0), MAIN (occ 1), FULL (main+skid, occ 2). in_ready = (state != FULL), registered.
//    EMPTY: accept -> MAIN.
//    MAIN: accept & consume -> MAIN (main<=in); accept & !consume -> FULL (skid<=in); consume & !accept -> EMPTY.
//    FULL: consume -> MAIN (main<=skid); no accept possible. Outputs always come from main.
//  - SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); accept & consume same cycle -> stays full.
//  - Order preserved: skid entry never overtakes main.
//  - flush=1: next state EMPTY, occupancy 0, in_ready 1 next cycle; a beat offered in the flush cycle is dropped
//    even if in_ready=1; consumption by MEM in the flush cycle is still legal (handshake completes, then squashed).
//  - rst asserted mid-operation: immediate clear as reset; held entries lost.
//  - Payload held stable while out_valid & !out_ready (required by MEM stage).
// STRUCTURE
//  - Shared package cpu_pipe_pkg: typedef struct packed exe_mem_payload_t {wb, mem_read, mem_write, dest, alu_res, val_rm};
//    occupancy state encodings (OCC_EMPTY=2'd0, OCC_MAIN=2'd1, OCC_FULL=2'd2).
//  - One sub-module: pipe_skid_buf #(W) — generic payload-agnostic skid buffer (valid/ready, flush);
//    exe_mem_pipe_reg packs/unpacks the struct and applies control gating. SKID selects generate branch.
// TESTING
//  1. Reset mid-FULL: fill 2 beats with out_ready=0, assert rst -> out_valid=0, occupancy=0, out_wb=0 immediately.
//  2. Streaming: in_valid=1, out_ready=1, alu_res 0x10,0x20,0x30 on 3 cycles -> out_alu_res 0x10,0x20,0x30 one cycle later, in_ready stays 1.
//  3. Backpressure (SKID=1): out_ready=0, beats A=0xA, B=0xB -> occupancy 2, in_ready=0; release out_ready -> A then B, no loss/dup.
//  4. Flush: occupancy 2, flush=1 with in_valid=1 dest=4'h7 -> next cycle out_valid=0, occupancy 0, beat 7 never emitted.
//  5. Control gating: beat wb=1 mem_write=1 consumed, no new beat -> out_wb=0, out_mem_write=0, out_alu_res unchanged.
//  6. SKID=0: out_valid=1, out_ready=1, in_valid=1 same cycle -> in_ready=1 combinationally, new beat follows without bubble.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: EXE->MEM payload layout and skid-buffer occupancy states.
package cpu_pipe_pkg;

  localparam int unsigned EXE_MEM_DATA_W = 32;
  localparam int unsigned EXE_MEM_DEST_W = 4;

  typedef struct packed {
    logic                      wb;
    logic                      mem_read;
    logic                      mem_write;
    logic [EXE_MEM_DEST_W-1:0] dest;
    logic [EXE_MEM_DATA_W-1:0] alu_res;
    logic [EXE_MEM_DATA_W-1:0] val_rm;
  } exe_mem_payload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with flush; SKID=1 adds a second slot so in_ready
// comes from a flop, SKID=0 is a single entry with pass-through ready.
module pipe_skid_buf
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter bit          SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic w_accept;
  logic w_consume;

  // A beat offered during flush is dropped regardless of in_ready.
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_consume = out_valid & out_ready;

  if (SKID) begin : g_skid
    occ_state_e   r_state;
    occ_state_e   w_next;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= OCC_EMPTY;
      else     r_state <= w_next;
    end

    always_comb begin
      w_next = r_state;
      if (flush) begin
        w_next = OCC_EMPTY;
      end else begin
        case (r_state)
          OCC_EMPTY: if (w_accept) w_next = OCC_MAIN;
          OCC_MAIN: begin
            if (w_accept && !w_consume)      w_next = OCC_FULL;
            else if (!w_accept && w_consume) w_next = OCC_EMPTY;
          end
          OCC_FULL:  if (w_consume) w_next = OCC_MAIN;
          default:   w_next = OCC_EMPTY;
        endcase
      end
    end

    always_comb begin
      in_ready  = (r_state != OCC_FULL);
      out_valid = (r_state != OCC_EMPTY);
      occupancy = r_state;
      out_data  = r_main;
    end

    // Outputs always come from main; skid refills main so order is preserved.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main <= '0;
        r_skid <= '0;
      end else if (!flush) begin
        case (r_state)
          OCC_EMPTY: if (w_accept) r_main <= in_data;
          OCC_MAIN: begin
            if (w_accept && w_consume) r_main <= in_data;
            else if (w_accept)         r_skid <= in_data;
          end
          OCC_FULL:  if (w_consume) r_main <= r_skid;
          default: ;
        endcase
      end
    end
  end else begin : g_single
    logic         r_valid;
    logic [W-1:0] r_main;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_main  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_main  <= in_data;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end

    always_comb begin
      in_ready  = ~r_valid | out_ready;
      out_valid = r_valid;
      occupancy = {1'b0, r_valid};
      out_data  = r_main;
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline boundary register: packs the stage payload into a skid buffer and
// gates the write-back/memory controls with out_valid.
module exe_mem_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_val_rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [1:0]        occupancy
);

  localparam int unsigned PW = 3 + DEST_W + 2 * DATA_W;

  // Field order matches exe_mem_payload_t; packed by concatenation so widths follow the parameters.
  logic [PW-1:0] w_in_pay;
  logic [PW-1:0] w_out_pay;
  logic          w_out_wb;
  logic          w_out_mem_read;
  logic          w_out_mem_write;

  assign w_in_pay = {in_wb, in_mem_read, in_mem_write, in_dest, in_alu_res, in_val_rm};

  pipe_skid_buf #(
    .W    (PW),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_pay),
    .occupancy (occupancy)
  );

  assign {w_out_wb, w_out_mem_read, w_out_mem_write, out_dest, out_alu_res, out_val_rm} = w_out_pay;

  assign out_wb        = w_out_wb        & out_valid;
  assign out_mem_read  = w_out_mem_read  & out_valid;
  assign out_mem_write = w_out_mem_write & out_valid;

endmodule
